// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised VGA raster timing generator driven from a single system clock.
// An internal divider produces one pixel tick every PIX_DIV clocks. On every
// tick the registered outputs load the decode of the current (hcnt, vcnt)
// position, and then the counters advance. Output latency is one pixel.
//
// Optional feature macro: VGA_TIMING_FRAMECNT_EN
//   defined   -> frame_cnt counts completed frames modulo 2^FC_W
//   undefined -> no frame counter register is built, frame_cnt is tied to 0
//
// Ports
//   clk          in   system clock
//   rst          in   synchronous active-high reset, has priority over run
//   run          in   1 = generate raster, 0 = hold idle / frame-start state
//   x, y         out  raw horizontal / vertical position of current pixel
//   de           out  display-area flag
//   hs, vs       out  sync outputs at configured polarity
//   pix_stb      out  one-clk pulse on every output update
//   line_start   out  one-clk pulse with pix_stb when x = 0
//   frame_start  out  one-clk pulse with pix_stb when x = 0 and y = 0
//   frame_cnt    out  completed frames, modulo 2^FC_W
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int   H_ACTIVE = 32'd640,
    parameter int   H_FRONT  = 32'd16,
    parameter int   H_SYNC   = 32'd96,
    parameter int   H_BACK   = 32'd48,
    parameter int   V_ACTIVE = 32'd480,
    parameter int   V_FRONT  = 32'd10,
    parameter int   V_SYNC   = 32'd2,
    parameter int   V_BACK   = 32'd33,
    parameter logic HS_NEG   = 1'b1,
    parameter logic VS_NEG   = 1'b1,
    parameter int   PIX_DIV  = 32'd2,
    parameter int   CNT_W    = 32'd11,
    parameter int   FC_W     = 32'd16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             de,
    output logic             hs,
    output logic             vs,
    output logic             pix_stb,
    output logic             line_start,
    output logic             frame_start,
    output logic [FC_W-1:0]  frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (PIX_DIV > 32'd1) ? $clog2(PIX_DIV) : 32'd1;

    localparam logic [DIV_W-1:0] DIV_LAST_C = DIV_W'(PIX_DIV - 32'd1);
    localparam logic [CNT_W-1:0] H_LAST_C   = CNT_W'(H_TOTAL - 32'd1);
    localparam logic [CNT_W-1:0] V_LAST_C   = CNT_W'(V_TOTAL - 32'd1);
    localparam logic [CNT_W-1:0] H_ACT_C    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG_C   = CNT_W'(H_ACTIVE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END_C   = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC - 32'd1);
    localparam logic [CNT_W-1:0] VS_BEG_C   = CNT_W'(V_ACTIVE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_END_C   = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC - 32'd1);

    // Refuse to elaborate configurations the counters cannot represent.
    generate
        if (PIX_DIV < 32'd1) begin : g_err_pix_div
            $error("vga_timing_gen: PIX_DIV must be >= 1");
        end
        if (H_TOTAL > ((32'd1 << CNT_W) - 32'd1)) begin : g_err_h_total
            $error("vga_timing_gen: H_TOTAL does not fit in CNT_W bits");
        end
        if (V_TOTAL > ((32'd1 << CNT_W) - 32'd1)) begin : g_err_v_total
            $error("vga_timing_gen: V_TOTAL does not fit in CNT_W bits");
        end
    endgenerate

    logic [DIV_W-1:0] div_r;
    logic [CNT_W-1:0] hcnt_r;
    logic [CNT_W-1:0] vcnt_r;
    logic [CNT_W-1:0] x_r;
    logic [CNT_W-1:0] y_r;
    logic             de_r;
    logic             hs_r;
    logic             vs_r;
    logic             pix_stb_r;
    logic             line_start_r;
    logic             frame_start_r;

    logic             tick_s;
    logic             h_wrap_s;
    logic             v_wrap_s;
    logic             de_s;
    logic             hs_act_s;
    logic             vs_act_s;
    logic [DIV_W-1:0] div_nxt_s;
    logic [CNT_W-1:0] hcnt_nxt_s;
    logic [CNT_W-1:0] vcnt_nxt_s;

    // Pixel tick and position decode of the counter value held before the tick.
    always_comb begin
        tick_s   = (div_r == DIV_LAST_C);
        h_wrap_s = (hcnt_r == H_LAST_C);
        v_wrap_s = (vcnt_r == V_LAST_C);
        de_s     = (hcnt_r < H_ACT_C) && (vcnt_r < V_ACT_C);
        hs_act_s = (hcnt_r >= HS_BEG_C) && (hcnt_r <= HS_END_C);
        vs_act_s = (vcnt_r >= VS_BEG_C) && (vcnt_r <= VS_END_C);
    end

    // Next divider / raster counter values; counters only move on a tick.
    always_comb begin
        div_nxt_s  = div_r;
        hcnt_nxt_s = hcnt_r;
        vcnt_nxt_s = vcnt_r;
        if (tick_s) begin
            div_nxt_s = {DIV_W{1'b0}};
            if (h_wrap_s) begin
                hcnt_nxt_s = {CNT_W{1'b0}};
                if (v_wrap_s) begin
                    vcnt_nxt_s = {CNT_W{1'b0}};
                end else begin
                    vcnt_nxt_s = vcnt_r + 1'b1;
                end
            end else begin
                hcnt_nxt_s = hcnt_r + 1'b1;
            end
        end else begin
            div_nxt_s = div_r + 1'b1;
        end
    end

    // Counters and registered outputs; idle (run = 0) is the same state as reset.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            div_r         <= {DIV_W{1'b0}};
            hcnt_r        <= {CNT_W{1'b0}};
            vcnt_r        <= {CNT_W{1'b0}};
            x_r           <= {CNT_W{1'b0}};
            y_r           <= {CNT_W{1'b0}};
            de_r          <= 1'b0;
            hs_r          <= HS_NEG;
            vs_r          <= VS_NEG;
            pix_stb_r     <= 1'b0;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            div_r         <= div_nxt_s;
            hcnt_r        <= hcnt_nxt_s;
            vcnt_r        <= vcnt_nxt_s;
            pix_stb_r     <= tick_s;
            line_start_r  <= tick_s && (hcnt_r == {CNT_W{1'b0}});
            frame_start_r <= tick_s && (hcnt_r == {CNT_W{1'b0}}) && (vcnt_r == {CNT_W{1'b0}});
            if (tick_s) begin
                x_r  <= hcnt_r;
                y_r  <= vcnt_r;
                de_r <= de_s;
                hs_r <= hs_act_s ^ HS_NEG;
                vs_r <= vs_act_s ^ VS_NEG;
            end else begin
                x_r  <= x_r;
                y_r  <= y_r;
                de_r <= de_r;
                hs_r <= hs_r;
                vs_r <= vs_r;
            end
        end
    end

`ifdef VGA_TIMING_FRAMECNT_EN
    logic [FC_W-1:0] frame_cnt_r;

    // Completed-frame counter: bumps on the tick that shows the last pixel of a
    // frame, holds while idle, clears only on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_r <= {FC_W{1'b0}};
        end else if (run && tick_s && h_wrap_s && v_wrap_s) begin
            frame_cnt_r <= frame_cnt_r + 1'b1;
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    assign frame_cnt = frame_cnt_r;
`else
    assign frame_cnt = {FC_W{1'b0}};
`endif

    assign x           = x_r;
    assign y           = y_r;
    assign de          = de_r;
    assign hs          = hs_r;
    assign vs          = vs_r;
    assign pix_stb     = pix_stb_r;
    assign line_start  = line_start_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a small raster (8x6 total, PIX_DIV=2, FC_W=2)
// checked against an arithmetic model plus a vector table and directed
// sequences, and a default 800x525 raster at PIX_DIV=1 for line-level checks.
module tb_vga_timing_gen;

    // Small configuration as seen from the outside
    localparam int S_HA = 4, S_HF = 1, S_HS = 2, S_HB = 1;
    localparam int S_VA = 3, S_VF = 1, S_VS = 1, S_VB = 1;
    localparam int S_H = S_HA + S_HF + S_HS + S_HB;
    localparam int S_V = S_VA + S_VF + S_VS + S_VB;
    localparam int S_FRAME = S_H * S_V;
    localparam int S_DIV = 2;
    localparam int S_FCMOD = 4;

`ifdef VGA_TIMING_FRAMECNT_EN
    localparam bit FC_EN = 1'b1;
`else
    localparam bit FC_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_s = 1'b1, run_s = 1'b0;
    logic [10:0] x_s, y_s;
    logic        de_s, hs_s, vs_s, pix_stb_s, line_start_s, frame_start_s;
    logic [1:0]  frame_cnt_s;

    logic        rst_d = 1'b1, run_d = 1'b0;
    logic [10:0] x_d, y_d;
    logic        de_d, hs_d, vs_d, pix_stb_d, line_start_d, frame_start_d;
    logic [15:0] frame_cnt_d;

    vga_timing_gen #(
        .H_ACTIVE(S_HA), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
        .V_ACTIVE(S_VA), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
        .HS_NEG(1'b1), .VS_NEG(1'b1), .PIX_DIV(S_DIV), .CNT_W(11), .FC_W(2)
    ) dut_s (
        .clk(clk), .rst(rst_s), .run(run_s), .x(x_s), .y(y_s), .de(de_s),
        .hs(hs_s), .vs(vs_s), .pix_stb(pix_stb_s), .line_start(line_start_s),
        .frame_start(frame_start_s), .frame_cnt(frame_cnt_s)
    );

    vga_timing_gen #(.PIX_DIV(1)) dut_d (
        .clk(clk), .rst(rst_d), .run(run_d), .x(x_d), .y(y_d), .de(de_d),
        .hs(hs_d), .vs(vs_d), .pix_stb(pix_stb_d), .line_start(line_start_d),
        .frame_start(frame_start_d), .frame_cnt(frame_cnt_d)
    );

    int n_chk = 0;
    int n_pass = 0;

    // Model state: clk edges since the last idle/reset edge, and frames
    // completed in earlier runs since the last reset.
    int k_m = 0;
    int fcb_m = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_update(input logic r, input logic rn);
        if (r) begin
            k_m = 0;
            fcb_m = 0;
        end else if (!rn) begin
            fcb_m = fcb_m + (k_m / S_DIV) / S_FRAME;
            k_m = 0;
        end else begin
            k_m++;
        end
    endtask

    // Expected outputs: pixel n (0-based, counted since start) is shown after
    // tick number n+1; a tick happens every S_DIV edges.
    task automatic check_model();
        int t, n, ex, ey, efc;
        logic ede, ehs, evs, eps, els, efs;
        logic [29:0] act, exp;
        t = k_m / S_DIV;
        eps = (k_m > 0) && (k_m % S_DIV == 0);
        if (t == 0) begin
            ex = 0; ey = 0; ede = 1'b0; ehs = 1'b1; evs = 1'b1;
        end else begin
            n = t - 1;
            ex = n % S_H;
            ey = (n / S_H) % S_V;
            ede = (ex < S_HA) && (ey < S_VA);
            ehs = !((ex >= S_HA + S_HF) && (ex <= S_HA + S_HF + S_HS - 1));
            evs = !((ey >= S_VA + S_VF) && (ey <= S_VA + S_VF + S_VS - 1));
        end
        els = eps && (ex == 0);
        efs = els && (ey == 0);
        efc = FC_EN ? ((fcb_m + t / S_FRAME) % S_FCMOD) : 0;
        act = {x_s, y_s, de_s, hs_s, vs_s, pix_stb_s, line_start_s, frame_start_s, frame_cnt_s};
        exp = {11'(ex), 11'(ey), ede, ehs, evs, eps, els, efs, 2'(efc)};
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL model k=%0d {x,y,de,hs,vs,pix,ls,fs,fc}: got %0d,%0d,%b%b%b%b%b%b,%0d expected %0d,%0d,%b%b%b%b%b%b,%0d",
                      k_m, x_s, y_s, de_s, hs_s, vs_s, pix_stb_s, line_start_s, frame_start_s, frame_cnt_s,
                      ex, ey, ede, ehs, evs, eps, els, efs, efc);
    endtask

    task automatic step(input logic r, input logic rn);
        rst_s = r;
        run_s = rn;
        @(posedge clk);
        model_update(r, rn);
        #1;
        check_model();
    endtask

    task automatic step_d(input logic r, input logic rn);
        rst_d = r;
        run_d = rn;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic rst; logic run;
        int x; int y;
        logic de; logic hs; logic vs; logic ps; logic ls; logic fs;
    } vec_t;

    vec_t vt[20];
    int fs_time[8];
    int fs_fc[8];
    int ls_time[2];

    initial begin
        int nfs, nls, vs_bad, hs_bad, found, fc_hold;
        int pix_gap, hs_low, vs_low, fc_nz;

        // Release from reset and walk one line, edge by edge.
        vt[0]  = '{1'b1,1'b1, 0,0, 1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0};
        vt[1]  = '{1'b0,1'b1, 0,0, 1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0};
        vt[2]  = '{1'b0,1'b1, 0,0, 1'b1,1'b1,1'b1, 1'b1,1'b1,1'b1};
        vt[3]  = '{1'b0,1'b1, 0,0, 1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0};
        vt[4]  = '{1'b0,1'b1, 1,0, 1'b1,1'b1,1'b1, 1'b1,1'b0,1'b0};
        vt[5]  = '{1'b0,1'b1, 1,0, 1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0};
        vt[6]  = '{1'b0,1'b1, 2,0, 1'b1,1'b1,1'b1, 1'b1,1'b0,1'b0};
        vt[7]  = '{1'b0,1'b1, 2,0, 1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0};
        vt[8]  = '{1'b0,1'b1, 3,0, 1'b1,1'b1,1'b1, 1'b1,1'b0,1'b0};
        vt[9]  = '{1'b0,1'b1, 3,0, 1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0};
        vt[10] = '{1'b0,1'b1, 4,0, 1'b0,1'b1,1'b1, 1'b1,1'b0,1'b0};
        vt[11] = '{1'b0,1'b1, 4,0, 1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0};
        vt[12] = '{1'b0,1'b1, 5,0, 1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0};
        vt[13] = '{1'b0,1'b1, 5,0, 1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0};
        vt[14] = '{1'b0,1'b1, 6,0, 1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0};
        vt[15] = '{1'b0,1'b1, 6,0, 1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0};
        vt[16] = '{1'b0,1'b1, 7,0, 1'b0,1'b1,1'b1, 1'b1,1'b0,1'b0};
        vt[17] = '{1'b0,1'b1, 7,0, 1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0};
        vt[18] = '{1'b0,1'b1, 0,1, 1'b1,1'b1,1'b1, 1'b1,1'b1,1'b0};
        vt[19] = '{1'b0,1'b1, 0,1, 1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0};

        for (int i = 0; i < 20; i++) begin
            step(vt[i].rst, vt[i].run);
            n_chk++;
            if ({x_s, y_s, de_s, hs_s, vs_s, pix_stb_s, line_start_s, frame_start_s} ==
                {11'(vt[i].x), 11'(vt[i].y), vt[i].de, vt[i].hs, vt[i].vs, vt[i].ps, vt[i].ls, vt[i].fs})
                n_pass++;
            else
                $display("FAIL vec[%0d] {x,y,de,hs,vs,pix,ls,fs}: got %0d,%0d,%b%b%b%b%b%b expected %0d,%0d,%b%b%b%b%b%b",
                         i, x_s, y_s, de_s, hs_s, vs_s, pix_stb_s, line_start_s, frame_start_s,
                         vt[i].x, vt[i].y, vt[i].de, vt[i].hs, vt[i].vs, vt[i].ps, vt[i].ls, vt[i].fs);
        end
        chk("vec_fc_first_frame", frame_cnt_s, 0);

        // Several full frames: periods, sync placement and frame counter wrap.
        nfs = 0; nls = 0; vs_bad = 0; hs_bad = 0;
        for (int i = 0; i < 400 && k_m < 400; i++) begin
            step(1'b0, 1'b1);
            if (frame_start_s && nfs < 8) begin
                fs_time[nfs] = k_m;
                fs_fc[nfs] = frame_cnt_s;
                nfs++;
            end
            if (line_start_s && nls < 2) begin
                ls_time[nls] = k_m;
                nls++;
            end
            if (pix_stb_s && ((vs_s == 1'b0) != (y_s == 11'd4))) vs_bad++;
            if (pix_stb_s && ((hs_s == 1'b0) != (x_s == 11'd5 || x_s == 11'd6))) hs_bad++;
        end
        chk("frame_start_count", nfs, 4);
        if (nfs >= 2) chk("frame_period", fs_time[1] - fs_time[0], 96);
        if (nls >= 2) chk("line_period", ls_time[1] - ls_time[0], 16);
        for (int i = 0; i < 4 && i < nfs; i++)
            chk($sformatf("fc_at_frame_start_%0d", i), fs_fc[i], FC_EN ? ((i + 1) % 4) : 0);
        chk("vs_placement_errors", vs_bad, 0);
        chk("hs_placement_errors", hs_bad, 0);

        // Drop run at x=2, y=1 of the next frame, then restart.
        found = 0;
        for (int i = 0; i < 300 && found == 0; i++) begin
            step(1'b0, 1'b1);
            if (pix_stb_s && x_s == 11'd2 && y_s == 11'd1 && k_m > 440) found = 1;
        end
        chk("find_x2_y1", found, 1);
        fc_hold = frame_cnt_s;
        chk("fc_before_drop", fc_hold, FC_EN ? 1 : 0);
        step(1'b0, 1'b0);
        chk("run0_x", x_s, 0);
        chk("run0_y", y_s, 0);
        chk("run0_de", de_s, 0);
        chk("run0_pix", pix_stb_s, 0);
        chk("run0_fc_hold", frame_cnt_s, fc_hold);
        step(1'b0, 1'b1);
        chk("restart_edge1_fs", frame_start_s, 0);
        step(1'b0, 1'b1);
        chk("restart_edge2_fs", frame_start_s, 1);
        chk("restart_edge2_x", x_s, 0);

        // One-clock reset in mid-frame.
        for (int i = 0; i < 50; i++) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        chk("midrst_x", x_s, 0);
        chk("midrst_de", de_s, 0);
        chk("midrst_fc", frame_cnt_s, 0);
        step(1'b0, 1'b1);
        chk("midrst_edge1_fs", frame_start_s, 0);
        step(1'b0, 1'b1);
        chk("midrst_edge2_fs", frame_start_s, 1);
        chk("midrst_edge2_de", de_s, 1);

        // Random run/rst traffic against the model.
        for (int i = 0; i < 1500; i++)
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 149) != 0));
        rst_s = 1'b1;
        run_s = 1'b0;

        // Default raster with PIX_DIV=1.
        step_d(1'b1, 1'b1);
        chk("d_rst_hs", hs_d, 1);
        chk("d_rst_pix", pix_stb_d, 0);
        step_d(1'b0, 1'b1);
        chk("d_first_fs", frame_start_d, 1);
        chk("d_first_x", x_d, 0);
        chk("d_first_de", de_d, 1);
        pix_gap = 0; hs_bad = 0; hs_low = 0; vs_low = 0; fc_nz = 0; nls = 0;
        for (int i = 1; i <= 1700; i++) begin
            step_d(1'b0, 1'b1);
            if (!pix_stb_d) pix_gap++;
            if ((hs_d == 1'b0) != (x_d >= 11'd656 && x_d <= 11'd751)) hs_bad++;
            if (i < 800 && hs_d == 1'b0) hs_low++;
            if (vs_d == 1'b0) vs_low++;
            if (frame_cnt_d != 16'd0) fc_nz++;
            if (line_start_d && nls < 2) begin
                ls_time[nls] = i;
                nls++;
            end
        end
        chk("d_pix_stb_gaps", pix_gap, 0);
        chk("d_hs_placement_errors", hs_bad, 0);
        chk("d_hs_low_width", hs_low, 96);
        chk("d_vs_low_early", vs_low, 0);
        chk("d_fc_nonzero", fc_nz, 0);
        chk("d_line_start_count", nls, 2);
        if (nls >= 2) chk("d_line_period", ls_time[1] - ls_time[0], 800);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
